// File: rtl/light_phase_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// light_phase_sequencer_pkg
//
// Shared definitions for the two-way intersection phase controller:
//   - PHASE_W and the phase/state encodings (N_GRN .. ARED_EN). The codes are
//     visible on the debug 'phase' output, so their values are fixed here.
//   - Default timing constants, in timebase ticks, used as parameter defaults.
//   - The lamp bundle type and the Moore lamp decode for a phase.
// -----------------------------------------------------------------------------
package light_phase_sequencer_pkg;

   localparam int PHASE_W = 3;

   // Codes 6 and 7 are unused; the sequencer treats them as illegal and
   // recovers to N_GRN.
   typedef enum logic [PHASE_W-1:0] {
      N_GRN   = 3'd0,
      N_YEL   = 3'd1,
      ARED_NE = 3'd2,
      E_GRN   = 3'd3,
      E_YEL   = 3'd4,
      ARED_EN = 3'd5
   } phase_e;

   // Default timing, in ticks of the external timebase.
   localparam int DEF_CNT_W  = 8;
   localparam int DEF_T_GMIN = 20;
   localparam int DEF_T_GMAX = 60;
   localparam int DEF_T_YEL  = 4;
   localparam int DEF_T_ARED = 2;
   localparam int DEF_T_WALK = 10;

   // One red/yellow/green triple per direction.
   typedef struct packed {
      logic n_r;
      logic n_y;
      logic n_g;
      logic e_r;
      logic e_y;
      logic e_g;
   } lamps_t;

   // Exactly one lamp per direction for every code. Illegal codes show red
   // both ways for the single cycle before the state register recovers.
   function automatic lamps_t decode_lamps(input phase_e p);
      lamps_t l;
      l = '0;
      case (p)
         N_GRN: begin
            l.n_g = 1'b1;
            l.e_r = 1'b1;
         end
         N_YEL: begin
            l.n_y = 1'b1;
            l.e_r = 1'b1;
         end
         E_GRN: begin
            l.n_r = 1'b1;
            l.e_g = 1'b1;
         end
         E_YEL: begin
            l.n_r = 1'b1;
            l.e_y = 1'b1;
         end
         default: begin
            // ARED_NE, ARED_EN and illegal codes
            l.n_r = 1'b1;
            l.e_r = 1'b1;
         end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/light_phase_sequencer_interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
//
// Shared phase interval counter. It restarts from zero on request and
// otherwise counts timebase ticks. It saturates at all-ones, so a phase that
// is held indefinitely (N_GRN with no demand) never wraps back below a
// threshold.
//
// Ports:
//   clk      in   system clock, rising edge
//   CLR      in   asynchronous active-low reset (count -> 0)
//   restart  in   synchronous clear; wins over tick
//   tick     in   one-cycle timebase strobe; count advances only when high
//   cnt      out  CNT_W-bit current count
// -----------------------------------------------------------------------------
module interval_timer
   import light_phase_sequencer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             restart,
   input  logic             tick,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         cnt_reg <= '0;
      end else if (restart) begin
         cnt_reg <= '0;
      end else if (tick && (cnt_reg != CNT_MAX)) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/light_phase_sequencer.sv
// -----------------------------------------------------------------------------
// light_phase_sequencer
//
// Two-way intersection phase controller. North (main street) rests in green;
// East (side street) is served only on demand from the car sensor or a
// pending pedestrian call. The cycle is
//   N_GRN -> N_YEL -> ARED_NE -> E_GRN -> E_YEL -> ARED_EN -> N_GRN
// timed by one shared interval counter that restarts on every phase change.
//
// All transitions are evaluated only on tick cycles and compare the count
// before that tick's increment, so "cnt >= T-1" means T ticks in the phase.
//
// Ports:
//   clk         in   system clock, rising edge
//   CLR         in   asynchronous active-low reset
//   tick        in   one-cycle timebase strobe
//   S           in   East car-sensor level (already synchronised)
//   PB_N, PB_E  in   North / East crosswalk button pulses
//   NR NY NG    out  North lamps (Moore decode of the phase register)
//   ER EY EG    out  East lamps
//   WALK_N      out  North pedestrian WALK
//   WALK_E      out  East pedestrian WALK
//   IC          out  one-cycle pulse while the counter sits at 0 after a
//                    phase change
//   phase       out  current phase code, for monitoring
// -----------------------------------------------------------------------------
module light_phase_sequencer
   import light_phase_sequencer_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int T_GMIN = DEF_T_GMIN,  // must be >= T_WALK
   parameter int T_GMAX = DEF_T_GMAX,  // must be >  T_GMIN
   parameter int T_YEL  = DEF_T_YEL,
   parameter int T_ARED = DEF_T_ARED,
   parameter int T_WALK = DEF_T_WALK
) (
   input  logic               clk,
   input  logic               CLR,
   input  logic               tick,
   input  logic               S,
   input  logic               PB_N,
   input  logic               PB_E,
   output logic               NR,
   output logic               NY,
   output logic               NG,
   output logic               ER,
   output logic               EY,
   output logic               EG,
   output logic               WALK_N,
   output logic               WALK_E,
   output logic               IC,
   output logic [PHASE_W-1:0] phase
);

   // Last count value of each interval (pre-increment compare).
   localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GMIN - 1);
   localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GMAX - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YEL - 1);
   localparam logic [CNT_W-1:0] ARED_LAST = CNT_W'(T_ARED - 1);
   localparam logic [CNT_W-1:0] WALK_LEN  = CNT_W'(T_WALK);

   // Pedestrian channel index: 0 = North, 1 = East.
   localparam int PED_N = 0;
   localparam int PED_E = 1;

   phase_e           state_reg;
   phase_e           state_next;
   logic             state_change;
   logic [CNT_W-1:0] cnt;
   logic             ic_reg;
   logic             demand;
   lamps_t           lamps;

   logic [1:0]       pb;
   logic [1:0]       enter_grn;
   logic [1:0]       in_grn;
   logic [1:0]       pend;
   logic [1:0]       walk;
   logic             walk_window;

   // --------------------------------------------------------------------
   // Interval counter
   // --------------------------------------------------------------------
   interval_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .CLR     (CLR),
      .restart (state_change),
      .tick    (tick),
      .cnt     (cnt)
   );

   // --------------------------------------------------------------------
   // Phase FSM
   // --------------------------------------------------------------------
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         state_reg <= N_GRN;
      end else begin
         state_reg <= state_next;
      end
   end

   // A North pedestrian call is demand too: it forces a full cycle so the
   // call is served at the next N_GRN entry.
   assign demand = S | pend[PED_E] | pend[PED_N];

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         N_GRN: begin
            if (tick && (cnt >= GMIN_LAST) && demand) begin
               state_next = N_YEL;
            end
         end
         N_YEL: begin
            if (tick && (cnt >= YEL_LAST)) begin
               state_next = ARED_NE;
            end
         end
         ARED_NE: begin
            if (tick && (cnt >= ARED_LAST)) begin
               state_next = E_GRN;
            end
         end
         E_GRN: begin
            // Max-out always ends East green; gap-out needs the sensor
            // clear and no East pedestrian call still waiting.
            if (tick && ((cnt >= GMAX_LAST) ||
                         ((cnt >= GMIN_LAST) && !S && !pend[PED_E]))) begin
               state_next = E_YEL;
            end
         end
         E_YEL: begin
            if (tick && (cnt >= YEL_LAST)) begin
               state_next = ARED_EN;
            end
         end
         ARED_EN: begin
            if (tick && (cnt >= ARED_LAST)) begin
               state_next = N_GRN;
            end
         end
         default: begin
            state_next = N_GRN;
         end
      endcase
   end

   assign state_change = (state_next != state_reg);

   // IC is the registered phase-change flag, so it lines up with cnt == 0
   // in the first cycle of the new phase.
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         ic_reg <= 1'b0;
      end else begin
         ic_reg <= state_change;
      end
   end

   // --------------------------------------------------------------------
   // Pedestrian latches and WALK
   // --------------------------------------------------------------------
   assign pb[PED_N]        = PB_N;
   assign pb[PED_E]        = PB_E;
   assign enter_grn[PED_N] = state_change && (state_next == N_GRN);
   assign enter_grn[PED_E] = state_change && (state_next == E_GRN);
   assign in_grn[PED_N]    = (state_reg == N_GRN);
   assign in_grn[PED_E]    = (state_reg == E_GRN);

   // The counter restarts on green entry, so cnt < T_WALK is the WALK
   // window measured from that entry.
   assign walk_window = (cnt < WALK_LEN);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ped
         logic pend_reg;
         logic walk_arm_reg;

         always_ff @(posedge clk or negedge CLR) begin
            if (!CLR) begin
               pend_reg     <= 1'b0;
               walk_arm_reg <= 1'b0;
            end else begin
               // A press on the entry edge itself stays pending: the set
               // term wins over the clear.
               pend_reg <= pb[gi] | (pend_reg & ~enter_grn[gi]);
               // Arm only from a call that was already pending before the
               // entry edge; disarm on any phase change otherwise.
               if (enter_grn[gi]) begin
                  walk_arm_reg <= pend_reg;
               end else if (state_change) begin
                  walk_arm_reg <= 1'b0;
               end
            end
         end

         assign pend[gi] = pend_reg;
         assign walk[gi] = walk_arm_reg & in_grn[gi] & walk_window;
      end
   endgenerate

   // --------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------
   assign lamps  = decode_lamps(state_reg);
   assign NR     = lamps.n_r;
   assign NY     = lamps.n_y;
   assign NG     = lamps.n_g;
   assign ER     = lamps.e_r;
   assign EY     = lamps.e_y;
   assign EG     = lamps.e_g;
   assign WALK_N = walk[PED_N];
   assign WALK_E = walk[PED_E];
   assign IC     = ic_reg;
   assign phase  = state_reg;

endmodule
